// File: rtl/scv_rominit_pkg.sv
// Shared types and constants for the ROM-init cart writer.
// Holds the write-word layout, the writer FSM states and the mirror-mask helper.
package scv_rominit_pkg;

    localparam int unsigned CART_ADDR_W        = 17;
    localparam int unsigned ROMINIT_BUSY_SLACK = 2;

    typedef struct packed {
        logic [CART_ADDR_W-2:0] addr;
        logic [15:0]            data;
        logic [1:0]             be;
    } wr_word_t;

    typedef enum logic {
        StIdle,
        StIssue
    } wr_state_e;

    // Smallest 2^k-1 that still covers address size-1; 0 for size 0 or 1.
    function automatic logic [31:0] mirror_mask(input logic [31:0] size);
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < 32; i++) begin
            if (({1'b0, m} + 33'd1) < {1'b0, size}) begin
                m = {m[30:0], 1'b1};
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/rominit_fifo.sv
// Width-generic synchronous FIFO for packed cart write words.
// DEPTH must be a power of two; a push into a full FIFO is ignored unless a pop frees the slot.
module rominit_fifo #(
    parameter int unsigned WIDTH = 34,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_data,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_data,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_free
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [PTR_W:0]   r_count;
    logic             w_push;
    logic             w_pop;

    assign w_pop  = i_pop & ~o_empty;
    assign w_push = i_push & (~o_full | w_pop);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PTR_W'(1);
            if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
            r_count <= r_count + (PTR_W + 1)'(w_push) - (PTR_W + 1)'(w_pop);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wptr] <= i_data;
    end

    assign o_data  = r_mem[r_rptr];
    assign o_full  = (r_count == DEPTH_CNT);
    assign o_empty = (r_count == '0);
    assign o_free  = DEPTH_CNT - r_count;

endmodule

// File: rtl/cart_rom_writer.sv
// Packs the ROM-init byte stream into 16-bit cart words and writes them through a req/ack port.
// Also tracks loaded cart size, the mirror mask, download completion and FIFO overflow.
module cart_rom_writer
    import scv_rominit_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned ADDR_W     = CART_ADDR_W
) (
    input  logic              i_clk_sys,
    input  logic              i_reset,
    input  logic              i_ioctl_download,
    input  logic              i_rominit_sel_cart,
    input  logic [ADDR_W-1:0] i_rominit_addr,
    input  logic [7:0]        i_rominit_data,
    input  logic              i_rominit_valid,
    output logic              o_rominit_busy,
    output logic              o_mem_req,
    output logic [ADDR_W-2:0] o_mem_addr,
    output logic [15:0]       o_mem_din,
    output logic [1:0]        o_mem_be,
    input  logic              i_mem_ack,
    output logic [ADDR_W:0]   o_cart_size,
    output logic [ADDR_W-1:0] o_cart_mask,
    output logic              o_load_done,
    output logic              o_overflow
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] BUSY_FREE = CNT_W'(ROMINIT_BUSY_SLACK);

    typedef struct packed {
        logic [ADDR_W-2:0] addr;
        logic [15:0]       data;
        logic [1:0]        be;
    } word_t;

    logic              r_dl, r_flush, r_wait_done, r_load_done, r_busy, r_ovf;
    logic              r_pend_vld, r_pend_lane;
    logic [ADDR_W-2:0] r_pend_addr;
    logic [7:0]        r_pend_data;
    logic              w_pend_vld_nxt, w_pend_lane_nxt;
    logic [ADDR_W-2:0] w_pend_addr_nxt;
    logic [7:0]        w_pend_data_nxt;
    logic              w_accept, w_rise, w_fall, w_push, w_pop, w_issue, w_done, w_dropped;
    logic              w_full, w_empty;
    logic [CNT_W-1:0]  w_free, w_free_nxt;
    word_t             w_push_word, w_head, w_pend_word;
    wr_state_e         r_state, w_state_nxt;
    logic              r_req;
    logic [ADDR_W-2:0] r_addr;
    logic [15:0]       r_din;
    logic [1:0]        r_be;
    logic [ADDR_W:0]   r_size, w_size_base, w_addr_p1;
    logic [ADDR_W-1:0] r_mask;
    logic [31:0]       w_mask_full;

    assign w_accept  = i_rominit_valid & i_rominit_sel_cart;
    assign w_rise    = i_ioctl_download & ~r_dl;
    assign w_fall    = ~i_ioctl_download & r_dl;
    assign w_addr_p1 = {1'b0, i_rominit_addr} + {{ADDR_W{1'b0}}, 1'b1};

    assign w_pend_word.addr = r_pend_addr;
    assign w_pend_word.data = r_pend_lane ? {r_pend_data, 8'h00} : {8'h00, r_pend_data};
    assign w_pend_word.be   = r_pend_lane ? 2'b10 : 2'b01;

    always_comb begin
        w_push          = 1'b0;
        w_push_word     = w_pend_word;
        w_pend_vld_nxt  = r_pend_vld;
        w_pend_lane_nxt = r_pend_lane;
        w_pend_addr_nxt = r_pend_addr;
        w_pend_data_nxt = r_pend_data;
        if (w_accept) begin
            if (r_pend_vld && r_pend_addr == i_rominit_addr[ADDR_W-1:1]
                && r_pend_lane != i_rominit_addr[0]) begin
                w_push           = 1'b1;
                w_push_word.data = r_pend_lane ? {r_pend_data, i_rominit_data}
                                               : {i_rominit_data, r_pend_data};
                w_push_word.be   = 2'b11;
                w_pend_vld_nxt   = 1'b0;
            end else begin
                w_push          = r_pend_vld;
                w_pend_vld_nxt  = 1'b1;
                w_pend_lane_nxt = i_rominit_addr[0];
                w_pend_addr_nxt = i_rominit_addr[ADDR_W-1:1];
                w_pend_data_nxt = i_rominit_data;
            end
        end else if (r_flush && r_pend_vld) begin
            w_push         = 1'b1;
            w_pend_vld_nxt = 1'b0;
        end
    end

    rominit_fifo #(
        .WIDTH ($bits(word_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk_sys),
        .i_reset (i_reset),
        .i_push  (w_push),
        .i_data  (w_push_word),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_free  (w_free)
    );

    // Busy tracks the occupancy after this cycle's push/pop so the flag is never a cycle late.
    assign w_dropped  = w_push & w_full & ~w_pop;
    assign w_free_nxt = w_free - CNT_W'(w_push & ~w_dropped) + CNT_W'(w_pop);

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_issue     = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (!w_empty) begin
                    w_issue     = 1'b1;
                    w_state_nxt = StIssue;
                end
            end
            StIssue: begin
                if (i_mem_ack) begin
                    w_pop       = 1'b1;
                    w_state_nxt = StIdle;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    assign w_done = r_wait_done & ~w_rise & ~w_accept & ~r_pend_vld & w_empty
                    & (r_state == StIdle);
    assign w_size_base = w_rise ? '0 : r_size;
    assign w_mask_full = mirror_mask(32'(r_size));

    always_ff @(posedge i_clk_sys) begin
        if (i_reset) begin
            r_dl        <= 1'b0;
            r_flush     <= 1'b0;
            r_wait_done <= 1'b0;
            r_load_done <= 1'b0;
            r_busy      <= 1'b0;
            r_ovf       <= 1'b0;
            r_pend_vld  <= 1'b0;
            r_pend_lane <= 1'b0;
            r_pend_addr <= '0;
            r_pend_data <= '0;
            r_state     <= StIdle;
            r_req       <= 1'b0;
            r_addr      <= '0;
            r_din       <= '0;
            r_be        <= '0;
            r_size      <= '0;
            r_mask      <= '0;
        end else begin
            r_dl        <= i_ioctl_download;
            r_flush     <= w_fall;
            r_load_done <= w_done;
            r_busy      <= (w_free_nxt <= BUSY_FREE);
            r_pend_vld  <= w_pend_vld_nxt;
            r_pend_lane <= w_pend_lane_nxt;
            r_pend_addr <= w_pend_addr_nxt;
            r_pend_data <= w_pend_data_nxt;
            r_state     <= w_state_nxt;
            if (w_fall) r_wait_done <= 1'b1;
            else if (w_rise || w_done) r_wait_done <= 1'b0;
            if (w_rise) r_ovf <= 1'b0;
            if (w_dropped) r_ovf <= 1'b1;
            if (w_issue) begin
                r_req  <= 1'b1;
                r_addr <= w_head.addr;
                r_din  <= w_head.data;
                r_be   <= w_head.be;
            end else if (w_pop) begin
                r_req <= 1'b0;
            end
            if (w_accept && w_addr_p1 > w_size_base) r_size <= w_addr_p1;
            else r_size <= w_size_base;
            if (w_rise) r_mask <= '0;
            else if (r_flush) r_mask <= w_mask_full[ADDR_W-1:0];
        end
    end

    assign o_rominit_busy = r_busy;
    assign o_mem_req      = r_req;
    assign o_mem_addr     = r_addr;
    assign o_mem_din      = r_din;
    assign o_mem_be       = r_be;
    assign o_cart_size    = r_size;
    assign o_cart_mask    = r_mask;
    assign o_load_done    = r_load_done;
    assign o_overflow     = r_ovf;

endmodule
